// File: rtl/gemm_pim_seq.sv
// Bit-serial processing-in-memory GEMV engine: N_CH signed dot products, one input bit plane per cycle.
// Optional macro GEMM_ADC_SAT_EN clamps each per-plane partial sum to an ADC_P-bit signed range.
module gemm_pim_seq #(
  parameter int N_CH      = 3,
  parameter int VEC_LEN   = 32,
  parameter int INPUT_BIT = 6,
  parameter int ADC_P     = 6,
  parameter int ACC_W     = 24
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [N_CH*VEC_LEN*INPUT_BIT-1:0] vec_in,
  input  logic [N_CH*VEC_LEN*INPUT_BIT-1:0] mat_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N_CH*ACC_W-1:0]             result,
  output logic                              busy
);

  localparam int OPW = N_CH*VEC_LEN*INPUT_BIT;
  localparam int PW  = INPUT_BIT + $clog2(VEC_LEN) + 1;
  localparam int CW  = $clog2(INPUT_BIT + 1);
  localparam logic [CW-1:0] N_PLANE = CW'(INPUT_BIT);

  if (ADC_P < 1) begin : g_adc_p_check
    $error("ADC_P must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           bsel;
  logic [CW-1:0]           sh;
  logic [OPW-1:0]          vec_q, mat_q;
  logic signed [PW-1:0]    part [N_CH];
  logic signed [PW-1:0]    adc  [N_CH];
  logic signed [PW-1:0]    p_q  [N_CH];
  logic signed [ACC_W-1:0] term [N_CH];
  logic signed [ACC_W-1:0] acc  [N_CH];

  // One cycle samples plane cnt into p_q while the previous plane's sample is
  // accumulated, so COMPUTE spans INPUT_BIT+1 cycles.
  always_comb begin
    bsel = (cnt_q < N_PLANE) ? cnt_q : '0;
    sh   = cnt_q - CW'(1);
    for (int unsigned c = 0; c < N_CH; c++) begin
      part[c] = '0;
      for (int unsigned k = 0; k < VEC_LEN; k++) begin
        if (vec_q[(c*VEC_LEN + k)*INPUT_BIT + 32'(bsel)])
          part[c] = part[c] + PW'($signed(mat_q[(c*VEC_LEN + k)*INPUT_BIT +: INPUT_BIT]));
      end
`ifdef GEMM_ADC_SAT_EN
      if (int'(part[c]) > (2**(ADC_P-1)) - 1)
        adc[c] = PW'((2**(ADC_P-1)) - 1);
      else if (int'(part[c]) < -(2**(ADC_P-1)))
        adc[c] = PW'(-(2**(ADC_P-1)));
      else
        adc[c] = part[c];
`else
      adc[c] = part[c];
`endif
      term[c] = ACC_W'(p_q[c]) <<< sh;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    result    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (cnt_q == N_PLANE) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        for (int unsigned c = 0; c < N_CH; c++) result[c*ACC_W +: ACC_W] = acc[c];
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      mat_q   <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        p_q[c] <= '0;
        acc[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q <= vec_in;
            mat_q <= mat_in;
            cnt_q <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
              p_q[c] <= '0;
              acc[c] <= '0;
            end
          end
        end
        COMPUTE: begin
          for (int unsigned c = 0; c < N_CH; c++) begin
            if (cnt_q != N_PLANE) p_q[c] <= adc[c];
            if (cnt_q != '0)
              acc[c] <= (cnt_q == N_PLANE) ? acc[c] - term[c] : acc[c] + term[c];
          end
          cnt_q <= (cnt_q == N_PLANE) ? '0 : cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_pim_seq.sv
// Directed self-checking bench for gemm_pim_seq at default parameters.
module tb_gemm_pim_seq;

  localparam int N_CH    = 3;
  localparam int VEC_LEN = 32;
  localparam int IB      = 6;
  localparam int ACC_W   = 24;
  localparam int OPW     = N_CH*VEC_LEN*IB;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [OPW-1:0]     vec_in;
  logic [OPW-1:0]     mat_in;
  logic               out_valid;
  logic               out_ready;
  logic [N_CH*ACC_W-1:0] result;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  gemm_pim_seq #(
    .N_CH(N_CH), .VEC_LEN(VEC_LEN), .INPUT_BIT(IB), .ADC_P(6), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .vec_in(vec_in), .mat_in(mat_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ch(input int c);
    return longint'($signed(result[c*ACC_W +: ACC_W]));
  endfunction

  task automatic set_ch(input int c, input int v, input int m);
    for (int k = 0; k < VEC_LEN; k++) begin
      vec_in[(c*VEC_LEN + k)*IB +: IB] = IB'(v);
      mat_in[(c*VEC_LEN + k)*IB +: IB] = IB'(m);
    end
  endtask

  // Accept one transaction, then count cycles to out_valid (bounded).
  // With junk set, in_valid stays high and operands toggle during COMPUTE.
  task automatic send_wait(input bit junk, output int latency);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = junk;
    latency = 0;
    while (!out_valid && latency < 40) begin
      if (junk) begin
        vec_in = ~vec_in;
        mat_in = ~mat_in;
      end
      @(negedge clk);
      latency++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e1, e2, e3, e4a, e4b;
`ifdef GEMM_ADC_SAT_EN
    e1 = 31; e2 = -31; e3 = -31; e4a = -96; e4b = -62;
`else
    e1 = 32; e2 = -992; e3 = -32; e4a = -480; e4b = -448;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vec_in = '0; mat_in = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_result", longint'(result), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);

    // all ones
    for (int c = 0; c < N_CH; c++) set_ch(c, 1, 1);
    send_wait(1'b0, lat);
    check("ones_latency", lat, 7);
    check("ones_busy", longint'(busy), 1);
    check("ones_in_ready", longint'(in_ready), 0);
    for (int c = 0; c < N_CH; c++) check($sformatf("ones_ch%0d", c), ch(c), e1);
    @(negedge clk);
    check("ones_idle_valid", longint'(out_valid), 0);
    check("ones_idle_ready", longint'(in_ready), 1);
    check("ones_idle_busy", longint'(busy), 0);

    // vec=-1, mat=31
    for (int c = 0; c < N_CH; c++) set_ch(c, -1, 31);
    send_wait(1'b0, lat);
    check("neg_latency", lat, 7);
    for (int c = 0; c < N_CH; c++) check($sformatf("neg_ch%0d", c), ch(c), e2);

    // ramp on channel 0, junk on inputs during COMPUTE
    set_ch(1, 0, 0);
    set_ch(2, 0, 0);
    for (int k = 0; k < VEC_LEN; k++) begin
      vec_in[k*IB +: IB] = IB'(k - 16);
      mat_in[k*IB +: IB] = IB'(2);
    end
    send_wait(1'b1, lat);
    check("ramp_latency", lat, 7);
    check("ramp_ch0", ch(0), e3);
    check("ramp_ch1", ch(1), 0);
    check("ramp_ch2", ch(2), 0);
    @(negedge clk);

    // back-pressure with a stray in_valid pulse while DONE
    out_ready = 1'b0;
    set_ch(0, 3, -5);
    set_ch(1, -2, 7);
    set_ch(2, 0, 9);
    send_wait(1'b0, lat);
    check("bp_latency", lat, 7);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_ch0", ch(0), e4a);
      check("bp_ch1", ch(1), e4b);
      check("bp_ch2", ch(2), 0);
      if (i == 3) begin
        for (int c = 0; c < N_CH; c++) set_ch(c, 1, 1);
        in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", longint'(out_valid), 0);
    check("bp_release_ready", longint'(in_ready), 1);
    @(negedge clk);
    check("bp_stay_idle", longint'(busy), 0);

    // reset during plane 3
    for (int c = 0; c < N_CH; c++) set_ch(c, 1, 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_result", longint'(result), 0);
    check("mid_rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < N_CH; c++) set_ch(c, -1, 31);
    send_wait(1'b0, lat);
    check("post_rst_latency", lat, 7);
    for (int c = 0; c < N_CH; c++) check($sformatf("post_rst_ch%0d", c), ch(c), e2);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_pim_seq.md
GEMM_PIM_SEQ -- requirements
Module: gemm_pim_seq

Interface
REQ-001 The block SHALL have parameter N_CH, default 3, giving the number of independent dot-product channels.
REQ-002 The block SHALL have parameter VEC_LEN, default 32, giving the elements per channel vector.
REQ-003 The block SHALL have parameter INPUT_BIT, default 6, giving the signed element width and the number of bit-serial compute cycles.
REQ-004 The block SHALL have parameter ADC_P, default 6, giving the per-bit-plane ADC precision in bits, signed.
REQ-005 The block SHALL have parameter ACC_W, default 24, giving the signed accumulator/result width per channel.
REQ-006 Port list, with one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  vec_in/mat_in valid.
- in_ready  out  1  block can accept.
- vec_in  in  N_CH*VEC_LEN*INPUT_BIT  signed elements; element (c,k) at bits [(c*VEC_LEN+k)*INPUT_BIT +: INPUT_BIT].
- mat_in  in  N_CH*VEC_LEN*INPUT_BIT  signed weights, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  N_CH*ACC_W  signed dot products; channel c at [c*ACC_W +: ACC_W].
- busy  out  1  high while in COMPUTE or DONE.

Function
REQ-007 The FSM SHALL have states IDLE, COMPUTE and DONE, with IDLE after reset.
REQ-008 In IDLE, in_ready SHALL be 1; a transfer occurs on a rising edge with in_valid&&in_ready, capturing vec_in and mat_in into registers, clearing all accumulators and the plane counter, and entering COMPUTE.
REQ-009 In COMPUTE, each cycle SHALL process one bit plane b (LSB first, b=0..INPUT_BIT-1); per channel, partial P = sum over k of bit_b(vec[c][k]) * mat[c][k], computed in signed arithmetic without overflow.
REQ-010 For b<INPUT_BIT-1, acc SHALL become acc + (P<<b); for b=INPUT_BIT-1 (sign plane), acc SHALL become acc - (P<<b), giving the two's-complement dot product.
REQ-011 After the plane INPUT_BIT-1 cycle, the FSM SHALL enter DONE; out_valid SHALL be 1 exactly INPUT_BIT+1 cycles after the accepting edge (7 cycles at default).
REQ-012 In DONE, result and out_valid SHALL be held stable until out_valid&&out_ready, and then return to IDLE with out_valid 0 on the next cycle.
REQ-013 in_ready SHALL be 0 in COMPUTE and DONE; there is no input/output overlap (no same-cycle DONE->accept).
REQ-014 Accumulation SHALL wrap modulo 2^ACC_W; ACC_W smaller than the exact width is a user error, with no flag.
REQ-015 in_valid in COMPUTE or DONE SHALL be ignored and SHALL NOT corrupt captured operands.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, in_ready=1 once released, out_valid=0, busy=0, result=0 and accumulators/plane counter=0, including mid-COMPUTE and mid-DONE, with no partial result surfaced.

Configuration
REQ-017 Macro GEMM_ADC_SAT_EN defined: each per-plane P SHALL be clamped to [-(2^(ADC_P-1)), 2^(ADC_P-1)-1] before shift and accumulate, modelling ADC saturation.
REQ-018 GEMM_ADC_SAT_EN undefined: P SHALL be used at full precision, and ADC_P SHALL be unused.

Verification
REQ-019 Defaults, all vec=1, all mat=1, out_ready=1 -> out_valid after 7 cycles, each channel result=32, then IDLE.
REQ-020 Defaults, no SAT, all vec=-1, all mat=31 -> each channel result=-992; with GEMM_ADC_SAT_EN -> -31.
REQ-021 Channel 0 vec[k]=k-16, mat[k]=2; other channels zero -> ch0=2*sum(k-16)=-32, ch1=ch2=0.
REQ-022 out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, and a new in_valid pulse is ignored; release -> one transfer, then IDLE.
REQ-023 rst_n asserted in plane 3 of COMPUTE -> out_valid=0, result=0 immediately; the next transaction yields a correct result.
